// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : csr_pkg
//  Purpose  : Shared definitions for the machine-mode CSR unit. It holds the
//             CSR address map, the mstatus/mie/mip bit positions, the sleep
//             FSM state encoding and the CSR operation encoding.
//  Options  : CSR_COUNTERS_EN (see csr_unit_m) selects the counter addresses.
//  Revision : 1.0  initial release
// ============================================================================
package csr_pkg;

  // CSR address map
  localparam logic [11:0] c_ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] c_ADDR_MIE      = 12'h304;
  localparam logic [11:0] c_ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] c_ADDR_MEPC     = 12'h341;
  localparam logic [11:0] c_ADDR_MIP      = 12'h344;
  localparam logic [11:0] c_ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] c_ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] c_ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] c_ADDR_MINSTRH  = 12'hB82;

  // mstatus bit positions
  localparam int c_MSTATUS_MIE    = 3;
  localparam int c_MSTATUS_MPIE   = 7;
  localparam int c_MSTATUS_MPP_LO = 11;
  localparam int c_MSTATUS_MPP_HI = 12;

  // mie / mip share the same bit positions
  localparam int c_MIP_MTIP = 7;
  localparam int c_MIP_MEIP = 11;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    SLEEP = 1'b1
  } csr_state_e;

  typedef enum logic [1:0] {
    OP_W = 2'd0,
    OP_S = 2'd1,
    OP_C = 2'd2
  } csr_op_e;

  // Decode the one-hot-or-none instruction flags into an operation.
  // With no flag set the result is OP_W, but the caller gates the write
  // enable separately so the default is harmless.
  function automatic csr_op_e csr_decode_op(input logic set_f, input logic clr_f);
    if (set_f)      return OP_S;
    else if (clr_f) return OP_C;
    else            return OP_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_counter.sv
`default_nettype none
// ============================================================================
//  Module   : csr_counter
//  Purpose  : CNT_BITS wide free-running counter whose low and high halves
//             can be overwritten independently. A half write replaces that
//             half only and suppresses the increment for that cycle.
//  Ports    : clk, rst      clock, asynchronous active-high reset
//             i_inc         increment enable
//             i_wr_lo       replace bits [DATA_BITS-1:0] with i_wdata
//             i_wr_hi       replace bits [CNT_BITS-1:DATA_BITS] with i_wdata
//             i_wdata       write data
//             o_count       current count
//  Revision : 1.0  initial release
// ============================================================================
module csr_counter #(
  parameter int CNT_BITS  = 64,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_inc,
  input  logic                 i_wr_lo,
  input  logic                 i_wr_hi,
  input  logic [DATA_BITS-1:0] i_wdata,
  output logic [CNT_BITS-1:0]  o_count
);

  localparam int c_HI_BITS = CNT_BITS - DATA_BITS;

  logic [CNT_BITS-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_wr_lo) begin
      r_count[DATA_BITS-1:0] <= i_wdata;
    end else if (i_wr_hi) begin
      r_count[CNT_BITS-1:DATA_BITS] <= i_wdata[c_HI_BITS-1:0];
    end else if (i_inc) begin
      r_count <= r_count + CNT_BITS'(1);
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/csr_unit_m.sv
`default_nettype none
// ============================================================================
//  Module   : csr_unit_m
//  Purpose  : Machine-mode CSR unit sitting behind the EX-stage CSR port.
//             Executes CSRRW/RS/RC, holds mstatus/mie/mip/mtvec/mepc, runs
//             the WFI sleep FSM and issues PC redirects for interrupt entry,
//             MRET and WFI wake-up.
//  Options  : CSR_COUNTERS_EN defined   -> mcycle/minstret (CNT_BITS wide)
//             CSR_COUNTERS_EN undefined -> counter addresses read 0, no flops
//  Ports    : clk, rst        clock, asynchronous active-high reset
//             i_pc            PC of the instruction in EX
//             i_csr_addr      CSR address
//             i_rs1_rdata     operand (rs1 or zimm)
//             i_reg_wr        instruction writes rd (read is side-effect free)
//             i_wr/i_set/i_clr CSRRW / CSRRS / CSRRC (at most one high)
//             i_mret, i_wfi   MRET / WFI in EX
//             i_retire        EX instruction commits this cycle
//             i_irq_ext       MEIP level
//             i_irq_timer     MTIP level
//             o_rd_wdata      pre-write CSR value (combinational)
//             o_redirect      one-cycle flush/redirect pulse
//             o_redirect_pc   redirect target
//             o_sleep         WFI sleep active
//  Revision : 1.0  initial release
// ============================================================================
module csr_unit_m
  import csr_pkg::*;
#(
  parameter int                   ADDR_BITS = 32,
  parameter int                   DATA_BITS = 32,
  parameter int                   CNT_BITS  = 64,
  parameter logic [DATA_BITS-1:0] MTVEC_RST = DATA_BITS'(32'h0001_0000)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] i_pc,
  input  logic [11:0]          i_csr_addr,
  input  logic [DATA_BITS-1:0] i_rs1_rdata,
  input  logic                 i_reg_wr,
  input  logic                 i_wr,
  input  logic                 i_set,
  input  logic                 i_clr,
  input  logic                 i_mret,
  input  logic                 i_wfi,
  input  logic                 i_retire,
  input  logic                 i_irq_ext,
  input  logic                 i_irq_timer,
  output logic [DATA_BITS-1:0] o_rd_wdata,
  output logic                 o_redirect,
  output logic [ADDR_BITS-1:0] o_redirect_pc,
  output logic                 o_sleep
);

  localparam logic [DATA_BITS-1:0] c_ALIGN_D = ~DATA_BITS'(3);
  localparam logic [ADDR_BITS-1:0] c_ALIGN_A = ~ADDR_BITS'(3);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  csr_state_e           r_state;
  logic                 r_sleep;
  logic                 r_redirect;
  logic [ADDR_BITS-1:0] r_redirect_pc;
  logic [ADDR_BITS-1:0] r_pc_wfi;
  logic                 r_st_mie;
  logic                 r_st_mpie;
  logic                 r_mie_mtie;
  logic                 r_mie_meie;
  logic [DATA_BITS-1:0] r_mtvec;
  logic [DATA_BITS-1:0] r_mepc;

  logic [DATA_BITS-1:0] w_mstatus;
  logic [DATA_BITS-1:0] w_mie;
  logic [DATA_BITS-1:0] w_mip;
  logic [DATA_BITS-1:0] w_old;
  logic [DATA_BITS-1:0] w_new;
  csr_op_e              w_op;
  logic                 w_run;
  logic                 w_we;
  logic                 w_we_mstatus;
  logic                 w_we_mie;
  logic                 w_we_mtvec;
  logic                 w_we_mepc;
  logic                 w_pend;
  logic                 w_take;
  logic                 w_mie_nxt;
  logic [DATA_BITS-1:0] w_mtvec_nxt;
  logic [ADDR_BITS-1:0] w_pc4;
  logic [ADDR_BITS-1:0] w_wfi4;

  // --------------------------------------------------------------------------
  // Architectural views of the trap CSRs
  // --------------------------------------------------------------------------
  always_comb begin
    w_mstatus                                    = '0;
    w_mstatus[c_MSTATUS_MIE]                     = r_st_mie;
    w_mstatus[c_MSTATUS_MPIE]                    = r_st_mpie;
    w_mstatus[c_MSTATUS_MPP_HI:c_MSTATUS_MPP_LO] = 2'b11;

    w_mie             = '0;
    w_mie[c_MIP_MTIP] = r_mie_mtie;
    w_mie[c_MIP_MEIP] = r_mie_meie;

    w_mip             = '0;
    w_mip[c_MIP_MTIP] = i_irq_timer;
    w_mip[c_MIP_MEIP] = i_irq_ext;
  end

  assign w_pend = (i_irq_timer & r_mie_mtie) | (i_irq_ext & r_mie_meie);
  assign w_take = w_pend & r_st_mie;

  // --------------------------------------------------------------------------
  // Counters
  // --------------------------------------------------------------------------
`ifdef CSR_COUNTERS_EN
  logic [CNT_BITS-1:0] w_mcycle;
  logic [CNT_BITS-1:0] w_minstret;

  csr_counter #(
    .CNT_BITS  (CNT_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (1'b1),
    .i_wr_lo (w_we && (i_csr_addr == c_ADDR_MCYCLE)),
    .i_wr_hi (w_we && (i_csr_addr == c_ADDR_MCYCLEH)),
    .i_wdata (w_new),
    .o_count (w_mcycle)
  );

  // Only instructions that actually commit count; WFI sleep stalls retire.
  csr_counter #(
    .CNT_BITS  (CNT_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_minstret (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_run & i_retire),
    .i_wr_lo (w_we && (i_csr_addr == c_ADDR_MINSTRET)),
    .i_wr_hi (w_we && (i_csr_addr == c_ADDR_MINSTRH)),
    .i_wdata (w_new),
    .o_count (w_minstret)
  );
`endif

  // --------------------------------------------------------------------------
  // Read mux (pre-write value)
  // --------------------------------------------------------------------------
  always_comb begin
    w_old = '0;
    case (i_csr_addr)
      c_ADDR_MSTATUS:  w_old = w_mstatus;
      c_ADDR_MIE:      w_old = w_mie;
      c_ADDR_MTVEC:    w_old = r_mtvec;
      c_ADDR_MEPC:     w_old = r_mepc;
      c_ADDR_MIP:      w_old = w_mip;
`ifdef CSR_COUNTERS_EN
      c_ADDR_MCYCLE:   w_old = w_mcycle[DATA_BITS-1:0];
      c_ADDR_MCYCLEH:  w_old = DATA_BITS'(w_mcycle[CNT_BITS-1:DATA_BITS]);
      c_ADDR_MINSTRET: w_old = w_minstret[DATA_BITS-1:0];
      c_ADDR_MINSTRH:  w_old = DATA_BITS'(w_minstret[CNT_BITS-1:DATA_BITS]);
`endif
      default:         w_old = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Write data and per-register enables
  // --------------------------------------------------------------------------
  assign w_op = csr_decode_op(i_set, i_clr);

  always_comb begin
    w_new = i_rs1_rdata;
    case (w_op)
      OP_W:    w_new = i_rs1_rdata;
      OP_S:    w_new = w_old | i_rs1_rdata;
      OP_C:    w_new = w_old & ~i_rs1_rdata;
      default: w_new = i_rs1_rdata;
    endcase
  end

  // i_reg_wr only selects whether rd is written by the pipeline; a CSR read
  // has no side effects here, so it does not gate anything.
  assign w_run        = (r_state == RUN);
  assign w_we         = w_run & i_retire & (i_wr | i_set | i_clr) & (i_reg_wr | ~i_reg_wr);
  assign w_we_mstatus = w_we && (i_csr_addr == c_ADDR_MSTATUS);
  assign w_we_mie     = w_we && (i_csr_addr == c_ADDR_MIE);
  assign w_we_mtvec   = w_we && (i_csr_addr == c_ADDR_MTVEC);
  assign w_we_mepc    = w_we && (i_csr_addr == c_ADDR_MEPC);

  // Values after the committing instruction's own CSR write; trap entry
  // saves/targets these so the instruction fully completes before the trap.
  assign w_mie_nxt   = w_we_mstatus ? w_new[c_MSTATUS_MIE] : r_st_mie;
  assign w_mtvec_nxt = w_we_mtvec ? (w_new & c_ALIGN_D) : r_mtvec;

  assign w_pc4  = (i_pc + ADDR_BITS'(4)) & c_ALIGN_A;
  assign w_wfi4 = (r_pc_wfi + ADDR_BITS'(4)) & c_ALIGN_A;

  // --------------------------------------------------------------------------
  // mie / mtvec
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mie_mtie <= 1'b0;
      r_mie_meie <= 1'b0;
      r_mtvec    <= MTVEC_RST & c_ALIGN_D;
    end else begin
      if (w_we_mie) begin
        r_mie_mtie <= w_new[c_MIP_MTIP];
        r_mie_meie <= w_new[c_MIP_MEIP];
      end
      if (w_we_mtvec) begin
        r_mtvec <= w_new & c_ALIGN_D;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Trap / sleep FSM with registered outputs. CSR writes to mstatus/mepc are
  // applied first; trap-related updates below override them when both occur.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RUN;
      r_sleep       <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_pc_wfi      <= '0;
      r_st_mie      <= 1'b0;
      r_st_mpie     <= 1'b0;
      r_mepc        <= '0;
    end else begin
      r_redirect <= 1'b0;

      if (w_we_mstatus) begin
        r_st_mie  <= w_new[c_MSTATUS_MIE];
        r_st_mpie <= w_new[c_MSTATUS_MPIE];
      end
      if (w_we_mepc) begin
        r_mepc <= w_new & c_ALIGN_D;
      end

      case (r_state)
        RUN: begin
          if (i_retire) begin
            if (i_mret) begin
              r_redirect    <= 1'b1;
              r_redirect_pc <= ADDR_BITS'(r_mepc);
              r_st_mie      <= r_st_mpie;
              r_st_mpie     <= 1'b1;
            end else if (i_wfi) begin
              // With an interrupt already pending WFI just falls through.
              if (!w_pend) begin
                r_state  <= SLEEP;
                r_sleep  <= 1'b1;
                r_pc_wfi <= i_pc;
              end
            end else if (w_take) begin
              r_mepc        <= DATA_BITS'(w_pc4);
              r_st_mpie     <= w_mie_nxt;
              r_st_mie      <= 1'b0;
              r_redirect    <= 1'b1;
              r_redirect_pc <= ADDR_BITS'(w_mtvec_nxt);
            end
          end
        end
        SLEEP: begin
          if (w_pend) begin
            r_state    <= RUN;
            r_sleep    <= 1'b0;
            r_redirect <= 1'b1;
            if (r_st_mie) begin
              r_mepc        <= DATA_BITS'(w_wfi4);
              r_st_mpie     <= 1'b1;
              r_st_mie      <= 1'b0;
              r_redirect_pc <= ADDR_BITS'(r_mtvec);
            end else begin
              r_redirect_pc <= w_wfi4;
            end
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign o_rd_wdata    = w_old;
  assign o_redirect    = r_redirect;
  assign o_redirect_pc = r_redirect_pc;
  assign o_sleep       = r_sleep;

endmodule
`default_nettype wire

// File: tb/tb_csr_unit_m.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_unit_m
//  Purpose  : Self-checking bench for csr_unit_m. Expected values are pushed
//             to a scoreboard queue when stimulus is driven and popped when
//             the DUT presents the corresponding output.
//  Options  : CSR_COUNTERS_EN selects the expected counter read values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_csr_unit_m;

`ifdef CSR_COUNTERS_EN
  localparam bit c_CNT_EN = 1'b1;
`else
  localparam bit c_CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [11:0] csr_addr;
  logic [31:0] rs1_rdata;
  logic        reg_wr, wr, set, clr, mret, wfi, retire, irq_ext, irq_timer;
  logic [31:0] rd_wdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        sleep;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] sb_val[$];
  string       sb_tag[$];

  csr_unit_m u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_pc         (pc),
    .i_csr_addr   (csr_addr),
    .i_rs1_rdata  (rs1_rdata),
    .i_reg_wr     (reg_wr),
    .i_wr         (wr),
    .i_set        (set),
    .i_clr        (clr),
    .i_mret       (mret),
    .i_wfi        (wfi),
    .i_retire     (retire),
    .i_irq_ext    (irq_ext),
    .i_irq_timer  (irq_timer),
    .o_rd_wdata   (rd_wdata),
    .o_redirect   (redirect),
    .o_redirect_pc(redirect_pc),
    .o_sleep      (sleep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    sb_tag.push_back(tag);
    sb_val.push_back(v);
  endtask

  task automatic sb_pop_check(input logic [31:0] got);
    string       t;
    logic [31:0] e;
    if (sb_val.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_underflow got=%h exp=<none>", got);
    end else begin
      t = sb_tag.pop_front();
      e = sb_val.pop_front();
      check_val(t, got, e);
    end
  endtask

  task automatic idle_inputs();
    retire = 1'b0; wr = 1'b0; set = 1'b0; clr = 1'b0;
    mret = 1'b0; wfi = 1'b0; reg_wr = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Combinational read of a CSR, no clock edge consumed.
  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    idle_inputs();
    csr_addr = a;
    sb_push(tag, exp);
    #1;
    sb_pop_check(rd_wdata);
  endtask

  // Committing CSR instruction: op 0=W 1=S 2=C
  task automatic csr_op(input logic [11:0] a, input logic [31:0] d, input int op);
    idle_inputs();
    csr_addr  = a;
    rs1_rdata = d;
    reg_wr    = 1'b1;
    wr        = (op == 0);
    set       = (op == 1);
    clr       = (op == 2);
    retire    = 1'b1;
    cyc();
    idle_inputs();
  endtask

  // Retire a non-CSR instruction (optionally MRET or WFI) at a given PC.
  task automatic retire_at(input logic [31:0] p, input logic is_mret, input logic is_wfi);
    idle_inputs();
    pc     = p;
    mret   = is_mret;
    wfi    = is_wfi;
    retire = 1'b1;
    cyc();
    idle_inputs();
  endtask

  // Bounded wait for the redirect pulse, then compare its target.
  task automatic wait_redirect(input string tag);
    int k;
    k = 0;
    while (!redirect && k < 10) begin
      cyc();
      k++;
    end
    if (!redirect) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout got=redirect0 exp=redirect1", tag);
      void'(sb_tag.pop_front());
      void'(sb_val.pop_front());
    end else begin
      sb_pop_check(redirect_pc);
    end
  endtask

  initial begin
    rst = 1'b1;
    pc = '0; csr_addr = '0; rs1_rdata = '0;
    irq_ext = 1'b0; irq_timer = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check_val("rst_redirect", {31'd0, redirect}, 32'd0);
    check_val("rst_sleep", {31'd0, sleep}, 32'd0);
    rd(12'h305, 32'h0001_0000, "rst_mtvec");
    rd(12'h300, 32'h0000_1800, "rst_mstatus");
    rd(12'h304, 32'h0, "rst_mie");
    rd(12'h341, 32'h0, "rst_mepc");

    // Basic read/modify/write and alignment
    csr_op(12'h341, 32'hFFFF_FFFF, 0);
    rd(12'h341, 32'hFFFF_FFFC, "mepc_align");
    csr_op(12'h305, 32'h0000_0F03, 1);
    rd(12'h305, 32'h0001_0F00, "mtvec_set");
    csr_op(12'h305, 32'h0000_0F03, 2);
    rd(12'h305, 32'h0001_0000, "mtvec_clr");
    csr_op(12'h300, 32'hFFFF_FFFF, 0);
    rd(12'h300, 32'h0000_1888, "mstatus_wr_all");
    csr_op(12'h300, 32'hFFFF_FFFF, 2);
    rd(12'h300, 32'h0000_1800, "mstatus_clr_all");

    // mip read-only reflection of the interrupt lines
    irq_timer = 1'b1;
    rd(12'h344, 32'h0000_0080, "mip_timer");
    irq_ext = 1'b1;
    rd(12'h344, 32'h0000_0880, "mip_both");
    csr_op(12'h344, 32'h0, 0);
    rd(12'h344, 32'h0000_0880, "mip_ro");
    irq_ext = 1'b0; irq_timer = 1'b0;

    // Unmapped address
    csr_op(12'h123, 32'hFFFF_FFFF, 0);
    rd(12'h123, 32'h0, "unmapped");

    // Counter half writes; write wins over the increment
    csr_op(12'hB00, 32'hFFFF_FFFF, 0);
    csr_op(12'hB80, 32'h0, 0);
    cyc();
    cyc();
    rd(12'hB00, c_CNT_EN ? 32'h1 : 32'h0, "mcycle_lo");
    rd(12'hB80, c_CNT_EN ? 32'h1 : 32'h0, "mcycle_hi");
    csr_op(12'hB82, 32'h0, 0);
    csr_op(12'hB02, 32'h5, 0);
    retire_at(32'h40, 1'b0, 1'b0);
    retire_at(32'h44, 1'b0, 1'b0);
    retire_at(32'h48, 1'b0, 1'b0);
    cyc();
    rd(12'hB02, c_CNT_EN ? 32'h8 : 32'h0, "minstret_lo");
    rd(12'hB82, 32'h0, "minstret_hi");

    // Interrupt entry while running
    csr_op(12'h304, 32'h0000_0800, 0);
    csr_op(12'h300, 32'h0000_0008, 1);
    rd(12'h300, 32'h0000_1808, "mie_on");
    irq_ext = 1'b1;
    sb_push("irq_redirect_pc", 32'h0001_0000);
    retire_at(32'h100, 1'b0, 1'b0);
    check_val("irq_redirect", {31'd0, redirect}, 32'd1);
    sb_pop_check(redirect_pc);
    rd(12'h341, 32'h0000_0104, "irq_mepc");
    rd(12'h300, 32'h0000_1880, "irq_mstatus");
    cyc();
    check_val("irq_redirect_pulse", {31'd0, redirect}, 32'd0);
    irq_ext = 1'b0;

    // MRET
    sb_push("mret_redirect_pc", 32'h0000_0104);
    retire_at(32'h1_0000, 1'b1, 1'b0);
    check_val("mret_redirect", {31'd0, redirect}, 32'd1);
    sb_pop_check(redirect_pc);
    rd(12'h300, 32'h0000_1888, "mret_mstatus");

    // WFI sleep, wake with MIE=0
    csr_op(12'h300, 32'h0000_0008, 2);
    csr_op(12'h304, 32'h0000_0080, 0);
    retire_at(32'h200, 1'b0, 1'b1);
    check_val("wfi_sleep", {31'd0, sleep}, 32'd1);
    cyc();
    check_val("wfi_hold", {31'd0, sleep}, 32'd1);
    irq_timer = 1'b1;
    sb_push("wake_nomie_pc", 32'h0000_0204);
    wait_redirect("wake_nomie");
    check_val("wake_nomie_sleep", {31'd0, sleep}, 32'd0);
    rd(12'h341, 32'h0000_0104, "wake_nomie_mepc");
    irq_timer = 1'b0;
    cyc();

    // WFI sleep, wake with MIE=1 (trap entry)
    csr_op(12'h300, 32'h0000_0008, 1);
    retire_at(32'h200, 1'b0, 1'b1);
    check_val("wfi2_sleep", {31'd0, sleep}, 32'd1);
    irq_timer = 1'b1;
    sb_push("wake_mie_pc", 32'h0001_0000);
    wait_redirect("wake_mie");
    check_val("wake_mie_sleep", {31'd0, sleep}, 32'd0);
    rd(12'h341, 32'h0000_0204, "wake_mie_mepc");
    rd(12'h300, 32'h0000_1880, "wake_mie_mstatus");
    cyc();

    // WFI with an interrupt already pending acts as a NOP
    retire_at(32'h300, 1'b0, 1'b1);
    check_val("wfi_pend_nop_sleep", {31'd0, sleep}, 32'd0);
    check_val("wfi_pend_nop_redir", {31'd0, redirect}, 32'd0);
    irq_timer = 1'b0;

    // Asynchronous reset during SLEEP
    csr_op(12'h305, 32'h0000_2000, 0);
    rd(12'h305, 32'h0000_2000, "mtvec_pre_rst");
    retire_at(32'h400, 1'b0, 1'b1);
    check_val("rst_wfi_sleep", {31'd0, sleep}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_sleep", {31'd0, sleep}, 32'd0);
    check_val("async_rst_redirect", {31'd0, redirect}, 32'd0);
    rd(12'h305, 32'h0001_0000, "async_rst_mtvec");
    cyc();
    rst = 1'b0;
    cyc();
    check_val("post_rst_sleep", {31'd0, sleep}, 32'd0);

    check_val("sb_empty", 32'(sb_val.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
